// File: rtl/branch_pkg.sv
// Shared types and constants for the branch sequencer: FSM state encoding,
// datapath width, sequential increment and the default reset PC.
package branch_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_CALC  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

endpackage

// File: rtl/pc_adder.sv
// The single shared adder of the sequencer: a + b modulo 2^XLEN, used both
// for PC increment and for branch-target computation.
module pc_adder #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);

  // Two's-complement wrap gives signed-offset addition for free.
  assign sum = a + b;

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter owner: steps the PC for fetch, resolves taken branches
// through one shared adder and pulses redirect when the PC is retargeted.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int                     XLEN        = branch_pkg::XLEN,
  parameter logic [XLEN-1:0]        RESET_PC    = branch_pkg::DEFAULT_RESET_PC,
  parameter int                     INSTR_BYTES = branch_pkg::INSTR_BYTES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_offset,
  output logic            br_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            redirect,
  output logic            misalign_err,
  output state_t          dbg_state
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("branch_sequencer: RESET_PC must be 4-byte aligned");
  end

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              misalign_q, misalign_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [XLEN-1:0]   add_a, add_b, add_sum;

  pc_adder #(.XLEN(XLEN)) u_pc_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  // Handshake: a branch request transfers on the rising edge where
  // br_valid && br_ready; br_ready depends only on the state (high in RUN),
  // and the requester keeps br_pc/br_offset/br_taken stable until then.
  assign br_ready     = (state_q == ST_RUN);
  assign redirect     = (state_q == ST_REDIRECT);
  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign misalign_err = misalign_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    misalign_d = misalign_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    target_d   = target_q;
    add_a      = opa_q;
    add_b      = opb_q;

    case (state_q)
      ST_RUN: begin
        add_a = pc_q;
        add_b = XLEN'(INSTR_BYTES);
        if (br_valid && br_taken) begin
          opa_d      = br_pc;
          opb_d      = br_offset;
          pc_valid_d = 1'b0;
          state_d    = ST_BR_CALC;
        end else if (advance && !stall) begin
          // A not-taken branch is consumed here without touching the PC.
          pc_d = add_sum;
        end
      end
      ST_BR_CALC: begin
        target_d = add_sum;
        if (add_sum[1:0] != 2'b00) begin
          misalign_d = 1'b1;
          state_d    = ST_ERR;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        pc_d       = target_q;
        pc_valid_d = 1'b1;
        state_d    = ST_RUN;
      end
      ST_ERR: begin
        pc_valid_d = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b1;
      misalign_q <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      target_q   <= target_d;
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed per-cycle vector table followed by
// randomized traffic checked against a cycle-level behavioural model.
module tb_branch_sequencer;
  import branch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset, advance, stall, br_valid, br_taken;
  logic [63:0] br_pc, br_offset;
  logic        br_ready, pc_valid, redirect, misalign_err;
  logic [63:0] pc;
  state_t      dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_sequencer #(.XLEN(64), .RESET_PC(RST_PC), .INSTR_BYTES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .advance      (advance),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .br_pc        (br_pc),
    .br_offset    (br_offset),
    .br_ready     (br_ready),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .redirect     (redirect),
    .misalign_err (misalign_err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, adv, stl, bv, bt;
    logic [63:0] bpc, boff;
    logic [63:0] e_pc;
    logic        e_valid, e_redir, e_ready, e_err;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: phase counts remaining bubble cycles of a taken branch.
  logic [63:0] m_pc, m_target;
  logic        m_valid, m_err;
  int          m_phase;

  task automatic model_edge();
    if (reset) begin
      m_pc = RST_PC; m_valid = 1'b1; m_err = 1'b0; m_phase = 0;
    end else if (m_err) begin
      m_valid = 1'b0;
    end else if (m_phase == 2) begin
      if (m_target % 4 != 0) begin m_err = 1'b1; m_phase = 0; end
      else m_phase = 1;
    end else if (m_phase == 1) begin
      m_pc = m_target; m_valid = 1'b1; m_phase = 0;
    end else if (br_valid && br_taken) begin
      m_target = br_pc + br_offset; m_phase = 2; m_valid = 1'b0;
    end else if (advance && !stall) begin
      m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic drive_step(input logic rst, adv, stl, bv, bt,
                            input logic [63:0] bpc, boff);
    reset = rst; advance = adv; stall = stl;
    br_valid = bv; br_taken = bt; br_pc = bpc; br_offset = boff;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] e_pc,
                       input logic e_valid, e_redir, e_ready, e_err);
    n_cmp += 5;
    if (pc !== e_pc) begin
      n_fail++; $display("FAIL %s pc: got %h want %h", tag, pc, e_pc);
    end
    if (pc_valid !== e_valid) begin
      n_fail++; $display("FAIL %s pc_valid: got %b want %b", tag, pc_valid, e_valid);
    end
    if (redirect !== e_redir) begin
      n_fail++; $display("FAIL %s redirect: got %b want %b", tag, redirect, e_redir);
    end
    if (br_ready !== e_ready) begin
      n_fail++; $display("FAIL %s br_ready: got %b want %b", tag, br_ready, e_ready);
    end
    if (misalign_err !== e_err) begin
      n_fail++; $display("FAIL %s misalign_err: got %b want %b", tag, misalign_err, e_err);
    end
  endtask

  function automatic vec_t v(input logic rst, adv, stl, bv, bt,
                             input logic [63:0] bpc, boff, e_pc,
                             input logic e_valid, e_redir, e_ready, e_err);
    vec_t r;
    r.rst = rst; r.adv = adv; r.stl = stl; r.bv = bv; r.bt = bt;
    r.bpc = bpc; r.boff = boff; r.e_pc = e_pc;
    r.e_valid = e_valid; r.e_redir = e_redir; r.e_ready = e_ready; r.e_err = e_err;
    return r;
  endfunction

  logic        req_active, req_taken;
  logic [63:0] req_pc, req_off;

  initial begin
    reset = 1'b1; advance = 1'b0; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    br_pc = '0; br_offset = '0;
    m_pc = RST_PC; m_target = '0; m_valid = 1'b1; m_err = 1'b0; m_phase = 0;

    //          rst adv stl bv bt  br_pc            br_offset              exp_pc       v  rd rdy err
    tbl.push_back(v(1, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h0,        1, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 64'h0,           64'h0,                 64'h4,        1, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 64'h0,           64'h0,                 64'h8,        1, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 64'h0,           64'h0,                 64'hC,        1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 64'hC,           64'hF4,                64'hC,        0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'hC,        0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h100,      1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 64'h100,         64'hFFFF_FFFF_FFFF_FFF0, 64'h100,    0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h100,      0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'hF0,       1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 64'hF0,          64'hFFFF_FFFF_FFFF_FF30, 64'hF0,     0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'hF0,       0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h20,       1, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 64'h18,          64'h40,                64'h20,       0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 64'h0,           64'h0,                 64'h20,       0, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 64'h0,           64'h0,                 64'h58,       1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 64'h58,          64'hFFFF_FFFF_FFFF_FFE8, 64'h58,     0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h58,       0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h40,       1, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 64'h40,          64'h100,               64'h44,       1, 0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 64'h0,           64'h0,                 64'h44,       1, 0, 1, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 64'h44,          64'h8,                 64'h44,       1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 64'h44,          64'h2,                 64'h44,       0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h44,       0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 64'h0,           64'h0,                 64'h44,       0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 1, 1, 64'h44,          64'h10,                64'h44,       0, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h0,        1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 64'h0,           64'hFFFF_FFFF_FFFF_FFFC, 64'h0,      0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h0,        0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 64'h0,           64'h0,                 64'h0,        1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 64'h0,           64'h80,                64'h0,        0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h0,        1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h0,        1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 64'h0,           64'h80,                64'h0,        0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h0,        0, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h0,        1, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 64'h0,           64'h0,                 64'h0,        1, 0, 1, 0));

    @(negedge clk);
    foreach (tbl[i]) begin
      drive_step(tbl[i].rst, tbl[i].adv, tbl[i].stl, tbl[i].bv, tbl[i].bt,
                 tbl[i].bpc, tbl[i].boff);
      check($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_valid,
            tbl[i].e_redir, tbl[i].e_ready, tbl[i].e_err);
    end

    req_active = 1'b0; req_taken = 1'b0; req_pc = '0; req_off = '0;
    for (int c = 0; c < 3000; c++) begin
      logic r_rst, accepted;
      if (!req_active && $urandom_range(0, 3) == 0) begin
        req_active = 1'b1;
        req_taken  = $urandom_range(0, 1) == 1;
        req_pc     = {$urandom, $urandom} & ~64'h3;
        req_off    = 64'($signed($urandom_range(0, 63)) - 32) * 64'd4;
        if ($urandom_range(0, 19) == 0) req_off = req_off + 64'd2;
      end
      r_rst    = m_err ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
      accepted = req_active && !r_rst && m_phase == 0 && !m_err;
      drive_step(r_rst, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                 req_active, req_taken, req_pc, req_off);
      if (accepted || r_rst) req_active = 1'b0;
      check($sformatf("rnd%0d", c), m_pc, m_valid,
            (m_phase == 1) && !m_err, (m_phase == 0) && !m_err, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Owns the 64-bit program counter for the processor core. It sequences one shared 64-bit adder between two jobs: the sequential PC+4 increment and the taken-branch target computation (branch PC + signed byte offset). It accepts resolved-branch requests from the execute stage with a ready/valid handshake and steps the PC for fetch. On a taken branch it redirects the PC and emits a one-cycle flush pulse to the upstream pipeline stages.

## Interface
Parameters:
- `XLEN`, 64, datapath width.
- `RESET_PC`, 64'h0, PC value after reset. Must be 4-byte aligned; elaboration fails otherwise.
- `INSTR_BYTES`, 4, sequential increment.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `advance` in 1: fetch consumed the current PC; step to the next instruction.
- `stall` in 1: blocks `advance` only.
- `br_valid` in 1: resolved-branch request.
- `br_taken` in 1: qualifies `br_valid`.
- `br_pc` in XLEN: PC of the branch instruction.
- `br_offset` in XLEN: signed two's-complement byte offset.
- `br_ready` out 1: branch request accepted this cycle.
- `pc` out XLEN: current fetch PC.
- `pc_valid` out 1: `pc` is usable by fetch.
- `redirect` out 1: one-cycle flush pulse for the upstream stages.
- `misalign_err` out 1: sticky flag for a misaligned branch target.

## Operation
- States: RUN, BR_CALC, REDIRECT, ERR.
- Reset values (any state, any cycle): state RUN, `pc`=RESET_PC, `pc_valid`=1, `redirect`=0, `misalign_err`=0, latched operands and target cleared.
- `br_ready` = (state==RUN), combinational from the state.
- Branch handshake: a request is accepted on the edge where `br_valid`&&`br_ready`. The requester holds `br_pc`, `br_offset` and `br_taken` stable until acceptance.
- Adder operand mux:
  - RUN: (`pc`, INSTR_BYTES).
  - BR_CALC: (latched `br_pc`, latched `br_offset`).
  - Other states: don't-care.
- Adder arithmetic: sum is modulo 2^64 with no overflow detection. 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- RUN, priority order:
  1. `br_valid`&&`br_taken`: latch operands, go to BR_CALC, `pc_valid`<=0. Any `advance` in the same cycle is dropped.
  2. `br_valid`&&!`br_taken`: request is accepted and consumed with no PC change. A simultaneous `advance`&&!`stall` still steps the PC.
  3. `advance`&&!`stall`: `pc`<=`pc`+4.
  4. Otherwise hold.
- BR_CALC:
  - Target <= adder sum.
  - If sum[1:0]!=0: go to ERR and set `misalign_err`.
  - Else: go to REDIRECT.
- REDIRECT: `pc`<=target, `redirect`=1 for this cycle only, `pc_valid`<=1, then RUN.
- ERR:
  - `pc_valid`=0, `br_ready`=0.
  - `pc` holds its pre-branch value.
  - Exit is by `reset` only.
- `advance` is ignored outside RUN.

## Timing
- Sequential step: edge E with `advance`&&!`stall` gives the new `pc` after E.
- Taken branch accepted at edge E0:
  - After E0: state BR_CALC, `pc_valid`=0.
  - After E1: state REDIRECT, `redirect`=1.
  - After E2: `pc`=target, `pc_valid`=1, `redirect`=0.
  - Result: two bubble cycles; the next branch can be accepted at E3.
- `br_ready`=0 for exactly the two cycles after acceptance.
- `reset` asserted in BR_CALC or REDIRECT aborts the branch. No `redirect` pulse follows.

## Structure
- Shared package `branch_pkg`:
  - State enum (RUN, BR_CALC, REDIRECT, ERR).
  - XLEN and INSTR_BYTES constants.
  - Default RESET_PC.
- One sub-module, `pc_adder`: a combinational 64-bit signed-offset adder (a, b, sum). This is the only adder in the block; the controller owns the operand mux and all registers.

## Test plan
- Reset then three `advance` pulses → `pc` = 0x0, 0x4, 0x8, 0xC. `pc_valid` stays 1 and `br_ready` stays 1.
- `pc`=0x100, taken branch with `br_pc`=0x100, `br_offset`=-16 (0xFFFF_FFFF_FFFF_FFF0) → `redirect` pulses two cycles after acceptance, then `pc`=0xF0 with `pc_valid`=1.
- Taken branch and `advance` in the same cycle at `pc`=0x20, offset +0x40, `br_pc`=0x18 → `advance` is dropped and the final `pc`=0x58.
- Not-taken branch plus `advance` at `pc`=0x40 → `pc`=0x44 and no `redirect`. `stall`=1 with `advance`=1 → `pc` holds.
- Offset +2 → ERR: `misalign_err`=1, `pc_valid`=0, `br_ready`=0, and the state persists until `reset` restores `pc`=RESET_PC.
- `pc`=0xFFFF_FFFF_FFFF_FFFC plus `advance` → `pc`=0. `reset` asserted during BR_CALC → `pc`=RESET_PC next cycle, with no `redirect` pulse.
